// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates single-cycle and FIFO-buffered multi-cycle
// results onto the register file write port and tracks pending multi-cycle writes.
module regfile_wb_ctrl #(
  parameter int unsigned D_WIDTH       = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            p_valid,
  output logic                            p_ready,
  input  logic [ADDRESS_WIDTH-1:0]        p_rd,
  input  logic [D_WIDTH-1:0]              p_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [ADDRESS_WIDTH-1:0]        s_rd,
  input  logic [D_WIDTH-1:0]              s_data,
  input  logic                            issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]        issue_rd,
  output logic [2**ADDRESS_WIDTH-1:0]     busy,
  output logic                            wr_en,
  output logic [ADDRESS_WIDTH-1:0]        a3,
  output logic [D_WIDTH-1:0]              din,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int unsigned NREG = 2**ADDRESS_WIDTH;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);

  logic [ADDRESS_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
  logic [D_WIDTH-1:0]       data_mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [SW-1:0]            starve_cnt;

  logic                     fifo_full, fifo_empty, force_drain;
  logic                     p_fire, s_fire, enq, pop;
  logic [ADDRESS_WIDTH-1:0] head_rd;
  logic [D_WIDTH-1:0]       head_data;

  logic [PW-1:0]            wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]            count_n;
  logic [SW-1:0]            starve_n;
  logic [NREG-1:0]          busy_n;
  logic                     wr_en_n;
  logic [ADDRESS_WIDTH-1:0] a3_n;
  logic [D_WIDTH-1:0]       din_n;

  // Ready signals depend only on registered state.
  assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  assign force_drain = (starve_cnt == SW'(STARVE_LIMIT));
  assign p_ready     = ~force_drain;
  assign s_ready     = ~fifo_full;

  assign p_fire    = p_valid & p_ready;
  assign s_fire    = s_valid & s_ready;
  assign enq       = s_fire & (s_rd != '0);
  assign pop       = ~p_fire & ~fifo_empty;
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Next-state: arbitration, FIFO bookkeeping, starvation and scoreboard.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = fifo_count;
    starve_n = '0;
    busy_n   = busy;
    wr_en_n  = 1'b0;
    a3_n     = a3;
    din_n    = din;

    if (enq) wr_ptr_n = wr_ptr + PW'(1);
    if (pop) rd_ptr_n = rd_ptr + PW'(1);
    if (enq && !pop)      count_n = fifo_count + CW'(1);
    else if (pop && !enq) count_n = fifo_count - CW'(1);

    if (fifo_full && p_fire) starve_n = starve_cnt + SW'(1);

    if (p_fire) begin
      wr_en_n = (p_rd != '0);
      a3_n    = p_rd;
      din_n   = p_data;
    end else if (pop) begin
      wr_en_n = 1'b1;
      a3_n    = head_rd;
      din_n   = head_data;
    end

    // Clear before set so a same-cycle reissue keeps the register busy.
    if (pop) busy_n[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_n[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      starve_cnt <= '0;
      busy       <= '0;
      wr_en      <= 1'b0;
      a3         <= '0;
      din        <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      fifo_count <= count_n;
      starve_cnt <= starve_n;
      busy       <= busy_n;
      wr_en      <= wr_en_n;
      a3         <= a3_n;
      din        <= din_n;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr]   <= s_rd;
      data_mem[wr_ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with hand-computed expectations.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid, s_valid, issue_valid;
  logic        p_ready, s_ready;
  logic [4:0]  p_rd, s_rd, issue_rd;
  logic [31:0] p_data, s_data;
  logic [31:0] busy;
  logic        wr_en;
  logic [4:0]  a3;
  logic [31:0] din;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  regfile_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_data(s_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy(busy), .wr_en(wr_en), .a3(a3), .din(din), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p_valid = 0; s_valid = 0; issue_valid = 0;
    p_rd = 0; s_rd = 0; issue_rd = 0; p_data = 0; s_data = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL reset_p_ready got=%b exp=1", p_ready); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (a3 !== 5'd0 || din !== 32'h0) begin errors++; $display("FAIL reset_a3_din got=%0d/%h exp=0/0", a3, din); end
  endtask

  task automatic test_primary();
    p_valid = 1; p_rd = 5; p_data = 32'hDEADBEEF;
    step();
    p_valid = 0;
    checks++; if (wr_en !== 1'b1 || a3 !== 5'd5 || din !== 32'hDEADBEEF) begin
      errors++; $display("FAIL prim_write got=%b/%0d/%h exp=1/5/deadbeef", wr_en, a3, din); end
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL prim_hold got=%b exp=0", wr_en); end
    p_valid = 1; p_rd = 0; p_data = 32'h55;
    step();
    p_valid = 0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL prim_x0 got=%b exp=0", wr_en); end
  endtask

  task automatic test_secondary();
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sec_busy_set got=%b exp=1", busy[7]); end
    step(); step();
    s_valid = 1; s_rd = 7; s_data = 32'h12345678;
    step();
    s_valid = 0;
    checks++; if (fifo_count !== 3'd1 || wr_en !== 1'b0 || busy[7] !== 1'b1) begin
      errors++; $display("FAIL sec_enq got=%0d/%b/%b exp=1/0/1", fifo_count, wr_en, busy[7]); end
    step();
    checks++; if (wr_en !== 1'b1 || a3 !== 5'd7 || din !== 32'h12345678) begin
      errors++; $display("FAIL sec_pop got=%b/%0d/%h exp=1/7/12345678", wr_en, a3, din); end
    checks++; if (busy[7] !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL sec_busy_clr got=%b/%0d exp=0/0", busy[7], fifo_count); end
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL sec_idle got=%b exp=0", wr_en); end
    s_valid = 1; s_rd = 0; s_data = 32'h77;
    step();
    s_valid = 0;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL sec_x0 got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_starve();
    p_valid = 1; p_rd = 10; p_data = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1; s_rd = 5'(i); s_data = 32'h100 + 32'(i);
      step();
    end
    s_valid = 0;
    checks++; if (fifo_count !== 3'd4 || s_ready !== 1'b0) begin
      errors++; $display("FAIL starve_full got=%0d/%b exp=4/0", fifo_count, s_ready); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL starve_pready_%0d got=%b exp=1", c, p_ready); end
      step();
    end
    checks++; if (p_ready !== 1'b0 || wr_en !== 1'b1 || a3 !== 5'd10) begin
      errors++; $display("FAIL starve_block got=%b/%b/%0d exp=0/1/10", p_ready, wr_en, a3); end
    step();
    p_valid = 0;
    checks++; if (wr_en !== 1'b1 || a3 !== 5'd1 || din !== 32'h101 || fifo_count !== 3'd3 || p_ready !== 1'b1) begin
      errors++; $display("FAIL starve_drain got=%b/%0d/%h/%0d/%b exp=1/1/101/3/1", wr_en, a3, din, fifo_count, p_ready); end
    for (int i = 2; i <= 4; i++) begin
      step();
      checks++; if (wr_en !== 1'b1 || a3 !== 5'(i) || din !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL drain_order_%0d got=%b/%0d/%h", i, wr_en, a3, din); end
    end
    step();
    checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL drain_done got=%b/%0d exp=0/0", wr_en, fifo_count); end
  endtask

  task automatic test_set_wins();
    issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0;
    s_valid = 1; s_rd = 9; s_data = 32'h99;
    step();
    s_valid = 0;
    issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0;
    checks++; if (wr_en !== 1'b1 || a3 !== 5'd9 || busy[9] !== 1'b1) begin
      errors++; $display("FAIL set_wins got=%b/%0d/%b exp=1/9/1", wr_en, a3, busy[9]); end
    step();
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL set_wins_hold got=%h exp=00000200", busy); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_rd = 12;
    p_valid = 1; p_rd = 11; p_data = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_rd = 5'(12 + i); s_data = 32'hC0 + 32'(i);
      step();
      issue_valid = 0;
    end
    s_valid = 0;
    checks++; if (fifo_count !== 3'd3 || wr_en !== 1'b1 || busy === 32'h0) begin
      errors++; $display("FAIL premid got=%0d/%b/%h exp=3/1/nonzero", fifo_count, wr_en, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0 || busy !== 32'h0) begin
      errors++; $display("FAIL async_rst got=%b/%0d/%h exp=0/0/0", wr_en, fifo_count, busy); end
    p_valid = 0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0) begin
        errors++; $display("FAIL post_rst_%0d got=%b/%0d exp=0/0", c, wr_en, fifo_count); end
    end
  endtask

  initial begin
    test_reset();
    test_primary();
    test_secondary();
    test_starve();
    test_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
